operand_pair_streamer: RTL

//  Buffered successor to the combinational input/weight selector. Holds the neuron input vector
//  and weight vector in two internal memories loaded through a write port. On a start command it

---
 rtl/operand_pair_streamer.sv | 90 +++++++++
 1 files changed

// File: rtl/operand_pair_streamer.sv
// operand_pair_streamer: buffers input/weight vectors and streams (input, weight) pairs over valid/ready
module operand_pair_streamer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_in_en,
  input  logic              wr_w_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_in_data,
  input  logic [DATA_W-1:0] wr_w_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_in,
  output logic [DATA_W-1:0] out_w,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] in_mem [2**ADDR_W];
  logic [DATA_W-1:0] w_mem [2**ADDR_W];
  logic [ADDR_W-1:0] base_r, addr;
  logic [ADDR_W:0] len_r, cnt, cnt_nxt;
  assign cnt_nxt = cnt + {{ADDR_W{1'b0}}, 1'b1};
  assign addr = base_r + cnt[ADDR_W-1:0];
  always_ff @(posedge clk) begin
    if (wr_in_en) in_mem[wr_addr] <= wr_in_data;
    if (wr_w_en) w_mem[wr_addr] <= wr_w_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_in    <= '0;
      out_w     <= '0;
      out_idx   <= '0;
      base_r    <= '0;
      len_r     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            base_r <= base;
            len_r  <= len;
            cnt    <= '0;
            busy   <= 1'b1;
            done   <= (len == '0);
            state  <= (len == '0) ? DONE : STREAM;
          end
        end
        STREAM: begin
          if (!out_valid || out_ready) begin
            if (cnt < len_r) begin
              out_in    <= in_mem[addr];
              out_w     <= w_mem[addr];
              out_idx   <= addr;
              out_last  <= (cnt_nxt == len_r);
              out_valid <= 1'b1;
              cnt       <= cnt_nxt;
            end else begin
              out_valid <= 1'b0;
            end
          end
          if (out_valid && out_ready && out_last) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
